// File: rtl/success_watchdog_pkg.sv
// -----------------------------------------------------------------------------
// success_watchdog_pkg
// Shared types for the success watchdog:
//   wd_state_e   - FSM states (IDLE, ARMED, REPORT)
//   wd_result_t  - result record: pass flag plus cycle value
//   cnt_w_ok()   - elaboration-time check that the counter width can hold
//                  MAX_CYCLES
// -----------------------------------------------------------------------------
package success_watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2
  } wd_state_e;

  // The record is sized for the widest supported counter. The top level
  // narrows it to CNT_W on the way out.
  localparam int WD_RESULT_W = 32;

  typedef struct packed {
    logic                   pass;
    logic [WD_RESULT_W-1:0] cycles;
  } wd_result_t;

  // True when a cnt_w-bit counter can represent max_cycles without wrapping
  // and still fits in the result record.
  function automatic bit cnt_w_ok(input int cnt_w, input int max_cycles);
    return (cnt_w >= 1) && (cnt_w <= WD_RESULT_W) &&
           ((64'd1 << cnt_w) > 64'(max_cycles));
  endfunction

endpackage

// File: rtl/success_run_counter.sv
// -----------------------------------------------------------------------------
// success_run_counter
// Counts consecutive cycles with success_in high while enabled, and remembers
// the cycle index at which the current run began.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   clear          - synchronous clear of the run (used outside ARMED)
//   enable         - sample success_in this cycle
//   success_in     - monitored success flag
//   cyc_cnt        - current cycle index supplied by the top level
//   run_cnt        - length of the run before this cycle
//   run_start      - cycle index at which the stored run began
//   qualify        - this cycle completes a run of STABLE_CYCLES
// -----------------------------------------------------------------------------
module success_run_counter
  #(
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 1
  ) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             success_in,
    input  logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] run_start,
    output logic             qualify
  );

  // Compared as run_cnt == STABLE_CYCLES-1 so that run_cnt+1 cannot overflow.
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

  assign qualify = enable && success_in && (run_cnt == STABLE_M1);

  // NOTE: state updates use <= so every flop samples pre-edge values; a
  // blocking = here would let later statements see the updated value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      run_start <= '0;
    end else if (clear) begin
      run_cnt   <= '0;
      run_start <= '0;
    end else if (enable) begin
      if (success_in) begin
        if (run_cnt == '0) begin
          run_start <= cyc_cnt;
        end
        if (run_cnt != '1) begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/success_watchdog.sv
// -----------------------------------------------------------------------------
// success_watchdog
// Pass/fail monitor for a DUT success flag. After start, it counts cycles and
// passes once success_in has been high for STABLE_CYCLES consecutive cycles
// within the first MAX_CYCLES cycles; otherwise it fails. One result record
// is delivered over a valid/ready handshake.
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous active-low reset
//   start        - arm request (IDLE only)
//   abort        - cancel an armed check, no record produced
//   success_in   - monitored success flag
//   busy         - registered: ARMED or REPORT
//   done_valid   - result record available
//   done_ready   - consumer accepts the record
//   done_pass    - 1 = pass, 0 = timeout fail
//   done_cycles  - pass: start index of the qualifying run; fail: MAX_CYCLES
// -----------------------------------------------------------------------------
module success_watchdog
  import success_watchdog_pkg::*;
  #(
    parameter int MAX_CYCLES    = 21,
    parameter int STABLE_CYCLES = 1,
    parameter int CNT_W         = 16
  ) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             success_in,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_pass,
    output logic [CNT_W-1:0] done_cycles
  );

  if (!cnt_w_ok(CNT_W, MAX_CYCLES)) begin : g_bad_cnt_w
    $error("success_watchdog: CNT_W too small for MAX_CYCLES");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_CYCLES) begin : g_bad_stable
    $error("success_watchdog: STABLE_CYCLES must be in 1..MAX_CYCLES");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAIL_VAL = CNT_W'(MAX_CYCLES);

  wd_state_e        state, state_d;
  wd_result_t       result, result_d;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_start;
  logic [CNT_W-1:0] origin;
  logic             qualify;
  logic             armed;
  logic             accept;

  assign armed  = (state == ARMED);
  assign accept = done_valid && done_ready;
  // When the run begins this very cycle, run_start has not been written yet.
  assign origin = (run_cnt == '0) ? cyc_cnt : run_start;

  success_run_counter #(
    .CNT_W         (CNT_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_run (
    .clock      (clock),
    .reset      (reset),
    .clear      (!armed),
    .enable     (armed),
    .success_in (success_in),
    .cyc_cnt    (cyc_cnt),
    .run_cnt    (run_cnt),
    .run_start  (run_start),
    .qualify    (qualify)
  );

  // NOTE: defaults first so every path assigns state_d and result_d;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    result_d = result;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // abort > pass > fail
        if (abort) begin
          state_d = IDLE;
        end else if (qualify) begin
          state_d         = REPORT;
          result_d.pass   = 1'b1;
          result_d.cycles = WD_RESULT_W'(origin);
        end else if (cyc_cnt == LAST_IDX) begin
          state_d         = REPORT;
          result_d.pass   = 1'b0;
          result_d.cycles = WD_RESULT_W'(FAIL_VAL);
        end
      end
      REPORT: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      result     <= '0;
      cyc_cnt    <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      state      <= state_d;
      result     <= result_d;
      busy       <= (state != IDLE);
      // Drop valid on the accepting edge so a record is never taken twice.
      done_valid <= (state == REPORT) && !accept;
      if (!armed) begin
        cyc_cnt <= '0;
      end else if (cyc_cnt != LAST_IDX) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  assign done_pass   = result.pass;
  assign done_cycles = CNT_W'(result.cycles);

endmodule

// File: tb/tb_success_watchdog.sv
module tb_success_watchdog;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        success_in = 1'b0;
  logic        done_ready = 1'b0;

  logic        busy1, dv1, pass1;
  logic [15:0] cyc1;
  logic        busy3, dv3, pass3;
  logic [15:0] cyc3;

  logic        use3 = 1'b0;
  logic        busy, dv, pass;
  logic [15:0] cyc;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  success_watchdog dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .success_in(success_in), .busy(busy1), .done_valid(dv1),
    .done_ready(done_ready), .done_pass(pass1), .done_cycles(cyc1)
  );

  success_watchdog #(.STABLE_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .success_in(success_in), .busy(busy3), .done_valid(dv3),
    .done_ready(done_ready), .done_pass(pass3), .done_cycles(cyc3)
  );

  assign busy = use3 ? busy3 : busy1;
  assign dv   = use3 ? dv3   : dv1;
  assign pass = use3 ? pass3 : pass1;
  assign cyc  = use3 ? cyc3  : cyc1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0; success_in = 1'b0; done_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Arms the selected DUT, plays pat[i] on success_in for cycle index i and
  // returns the number of edges after the start edge at which done_valid
  // is first seen (-1 if it never rises within the budget).
  task automatic arm_run(input logic [31:0] pat, output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      success_in = (n <= 32) ? pat[n-1] : 1'b0;
      tick();
      if (dv === 1'b1) lat = n;
    end
    success_in = 1'b0;
  endtask

  // Counts done_valid cycles over a window with the DUT left idle.
  task automatic count_valid(input int ncyc, output int seen);
    seen = 0;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (dv === 1'b1) seen++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1); else passes++;
    checks++; if (dv1 !== 1'b0) $display("FAIL reset_valid: got %b want 0", dv1); else passes++;
    checks++; if (pass1 !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass1); else passes++;
    checks++; if (cyc1 !== 16'd0) $display("FAIL reset_cycles: got %0d want 0", cyc1); else passes++;
    checks++; if (dv3 !== 1'b0) $display("FAIL reset_valid3: got %b want 0", dv3); else passes++;
    do_reset();
    tick();
    checks++; if (busy1 !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy1); else passes++;
  endtask

  task automatic test_pass_basic();
    int lat;
    use3 = 1'b0;
    do_reset();
    arm_run(32'hFFFF_FFE0, lat);
    checks++; if (lat !== 7) $display("FAIL basic_latency: got %0d want 7", lat); else passes++;
    checks++; if (pass !== 1'b1) $display("FAIL basic_pass: got %b want 1", pass); else passes++;
    checks++; if (cyc !== 16'd5) $display("FAIL basic_cycles: got %0d want 5", cyc); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    checks++; if (dv !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", dv); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_hold: got %b want 1", busy); else passes++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_drop: got %b want 0", busy); else passes++;
  endtask

  task automatic test_timeout();
    int lat;
    use3 = 1'b0;
    do_reset();
    arm_run(32'h0, lat);
    checks++; if (lat !== 22) $display("FAIL timeout_latency: got %0d want 22", lat); else passes++;
    checks++; if (pass !== 1'b0) $display("FAIL timeout_pass: got %b want 0", pass); else passes++;
    checks++; if (cyc !== 16'd21) $display("FAIL timeout_cycles: got %0d want 21", cyc); else passes++;
  endtask

  task automatic test_last_index();
    int lat;
    use3 = 1'b0;
    do_reset();
    arm_run(32'h0010_0000, lat);
    checks++; if (lat !== 22) $display("FAIL last_latency: got %0d want 22", lat); else passes++;
    checks++; if (pass !== 1'b1) $display("FAIL last_pass: got %b want 1", pass); else passes++;
    checks++; if (cyc !== 16'd20) $display("FAIL last_cycles: got %0d want 20", cyc); else passes++;
  endtask

  task automatic test_stable3();
    int lat;
    use3 = 1'b1;
    do_reset();
    // 1,1,0,1,1,1 from index 2
    arm_run(32'h0000_00EC, lat);
    checks++; if (lat !== 9) $display("FAIL stable3_latency: got %0d want 9", lat); else passes++;
    checks++; if (pass !== 1'b1) $display("FAIL stable3_pass: got %b want 1", pass); else passes++;
    checks++; if (cyc !== 16'd5) $display("FAIL stable3_cycles: got %0d want 5", cyc); else passes++;
    // success_in high before arming must not shorten the run
    do_reset();
    success_in = 1'b1;
    repeat (4) tick();
    arm_run(32'hFFFF_FFFF, lat);
    checks++; if (lat !== 4) $display("FAIL prearm_latency: got %0d want 4", lat); else passes++;
    checks++; if (cyc !== 16'd0) $display("FAIL prearm_cycles: got %0d want 0", cyc); else passes++;
    use3 = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    use3 = 1'b0;
    do_reset();
    arm_run(32'h0000_0020, lat);
    checks++; if (lat !== 7) $display("FAIL bp_latency: got %0d want 7", lat); else passes++;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      abort = ~i[0];
      tick();
      checks++; if (dv !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, dv); else passes++;
      checks++; if (pass !== 1'b1) $display("FAIL bp_pass[%0d]: got %b want 1", i, pass); else passes++;
      checks++; if (cyc !== 16'd5) $display("FAIL bp_cycles[%0d]: got %0d want 5", i, cyc); else passes++;
    end
    start = 1'b0;
    abort = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    checks++; if (dv !== 1'b0) $display("FAIL bp_accept: got %b want 0", dv); else passes++;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL bp_idle: got %b want 0", busy); else passes++;
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    use3 = 1'b0;
    // reset while ARMED at index 7
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++; if (busy !== 1'b1) $display("FAIL armed_busy: got %b want 1", busy); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_armed_busy: got %b want 0", busy); else passes++;
    tick();
    reset = 1'b1;
    count_valid(30, seen);
    checks++; if (seen !== 0) $display("FAIL rst_armed_noresult: got %0d valid cycles want 0", seen); else passes++;
    // reset while REPORT
    arm_run(32'h0000_0008, lat);
    checks++; if (dv !== 1'b1) $display("FAIL report_valid: got %b want 1", dv); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (dv !== 1'b0) $display("FAIL rst_rep_valid: got %b want 0", dv); else passes++;
    checks++; if (pass !== 1'b0) $display("FAIL rst_rep_pass: got %b want 0", pass); else passes++;
    checks++; if (cyc !== 16'd0) $display("FAIL rst_rep_cycles: got %0d want 0", cyc); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_rep_busy: got %b want 0", busy); else passes++;
    tick();
    reset = 1'b1;
    count_valid(30, seen);
    checks++; if (seen !== 0) $display("FAIL rst_rep_noresult: got %0d valid cycles want 0", seen); else passes++;
    // abort at index 4
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passes++;
    count_valid(30, seen);
    checks++; if (seen !== 0) $display("FAIL abort_noresult: got %0d valid cycles want 0", seen); else passes++;
  endtask

  initial begin
    test_reset();
    test_pass_basic();
    test_timeout();
    test_last_index();
    test_stable3();
    test_backpressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
